fifomem_mc: RTL

- Single-clock, multi-channel FIFO buffer memory. Next generation of the async FIFO's dual-port storage array.
- NCH independent logical FIFOs share one storage array of NCH*DEPTH words. Each channel gets a fixed DEPTH-word region.
- Block owns the per-channel pointers, occupancy counts and full/empty flags, plus a registered read port with valid and sticky error flags.
- Sits behind packet/channel demux logic in the write-clock domain, where no clock crossing is needed.

---
 rtl/fifomem_mc.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fifomem_mc.sv
// Multi-channel single-clock FIFO buffer memory.
// NCH logical FIFOs share one NCH*DEPTH-word array. Each channel owns a fixed
// DEPTH-word region addressed as {channel, ptr[ASIZE-1:0]}.
// The block also keeps per-channel pointers, occupancy and flags, a registered
// read port with a valid strobe, and sticky overflow/underflow flags.
//
// Handshake: a write is accepted when wen=1 and the selected channel is not full.
// A read is accepted when ren=1 and the selected channel is not empty.
// Both decisions use the flags at the start of the cycle, so a same-channel
// push/pop never writes through to a full channel and never bypasses an empty one.
// An accepted read presents its word on rdata with rvalid=1 in the next cycle.
// Otherwise rvalid drops and rdata holds its last value.
module fifomem_mc #(
    parameter int ASIZE = 4,
    parameter int DSIZE = 8,
    parameter int CSIZE = 2
) (
    input  logic                              wclk,
    input  logic                              wrst_n,
    input  logic                              wen,
    input  logic [CSIZE-1:0]                  wch,
    input  logic [DSIZE-1:0]                  wdata,
    input  logic                              ren,
    input  logic [CSIZE-1:0]                  rch,
    output logic [DSIZE-1:0]                  rdata,
    output logic                              rvalid,
    output logic [(2**CSIZE)-1:0]             full,
    output logic [(2**CSIZE)-1:0]             empty,
    output logic [(2**CSIZE)*(ASIZE+1)-1:0]   count,
    output logic                              ovf,
    output logic                              udf,
    input  logic                              clr_err
);

    localparam int NCH   = 2**CSIZE;
    localparam int DEPTH = 2**ASIZE;
    localparam int PW    = ASIZE + 1;

    // Shared storage array (not reset)
    logic [DSIZE-1:0] mem [NCH*DEPTH];

    logic [PW-1:0]    wptr_q [NCH];
    logic [PW-1:0]    wptr_d [NCH];
    logic [PW-1:0]    rptr_q [NCH];
    logic [PW-1:0]    rptr_d [NCH];
    logic [PW-1:0]    cnt    [NCH];

    logic [DSIZE-1:0] rdata_q,  rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             ovf_q,    ovf_d;
    logic             udf_q,    udf_d;

    logic             wr_ok;
    logic             rd_ok;
    logic [CSIZE+ASIZE-1:0] waddr;
    logic [CSIZE+ASIZE-1:0] raddr;

    // Occupancy and flags, derived purely from the registered pointers
    always_comb begin
        count = '0;
        full  = '0;
        empty = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt[i]             = wptr_q[i] - rptr_q[i];
            full[i]            = (cnt[i] == PW'(DEPTH));
            empty[i]           = (cnt[i] == '0);
            count[i*PW +: PW]  = cnt[i];
        end
    end

    // Accept/reject decisions and array addresses for this cycle
    always_comb begin
        wr_ok = wen & ~full[wch];
        rd_ok = ren & ~empty[rch];
        waddr = {wch, wptr_q[wch][ASIZE-1:0]};
        raddr = {rch, rptr_q[rch][ASIZE-1:0]};
    end

    // Next-state: pointer advance, read port, sticky error flags
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wptr_d[i] = wptr_q[i];
            rptr_d[i] = rptr_q[i];
        end
        if (wr_ok) begin
            wptr_d[wch] = wptr_q[wch] + PW'(1);
        end
        if (rd_ok) begin
            rptr_d[rch] = rptr_q[rch] + PW'(1);
        end
        rdata_d  = rd_ok ? mem[raddr] : rdata_q;
        rvalid_d = rd_ok;
        // A new error in the same cycle as clr_err takes priority
        ovf_d    = (ovf_q & ~clr_err) | (wen & full[wch]);
        udf_d    = (udf_q & ~clr_err) | (ren & empty[rch]);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < NCH; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
            end
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage write port; a rejected write leaves the array untouched
    always_ff @(posedge wclk) begin
        if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule
